// File: rtl/systolic_feeder_if.sv
// Handshake and array-side bundle for the systolic feeder.
// The slave modport is the feeder's view; master is the producer/array side.
interface systolic_feeder_if #(
  parameter int width = 8,
  parameter int row   = 3,
  parameter int col   = 3
);
  logic                       w_valid;
  logic [col-1:0][width-1:0]  w_data;
  logic                       w_ready;
  logic                       f_valid;
  logic [row-1:0][width-1:0]  f_data;
  logic                       f_last;
  logic                       f_ready;
  logic [col-1:0][width-1:0]  weight_out;
  logic                       ctrl_out;
  logic [row-1:0][width-1:0]  feature_out;
  logic                       busy;
  logic                       done;

  modport slave (
    input  w_valid, w_data, f_valid, f_data, f_last,
    output w_ready, f_ready, weight_out, ctrl_out, feature_out, busy, done
  );

  modport master (
    output w_valid, w_data, f_valid, f_data, f_last,
    input  w_ready, f_ready, weight_out, ctrl_out, feature_out, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Loads one weight vector per tile, then streams feature vectors into the
// array through per-lane skew chains (lane r delayed r+1 cycles) and flushes.
module systolic_feeder #(
  parameter int width = 8,
  parameter int row   = 3,
  parameter int col   = 3
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  systolic_feeder_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

  localparam int                CNT_W      = $clog2(row + col) + 1;
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(row + col - 2);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CNT_W-1:0]           r_flush_cnt;
  logic [col-1:0][width-1:0]  r_weight;
  logic                       r_done;

  logic w_w_ready;
  logic w_f_ready;
  logic w_ctrl;
  logic w_busy;
  logic w_w_hs;
  logic w_f_hs;
  logic w_shift;
  logic w_flush_end;

  assign w_w_hs      = bus.w_valid & w_w_ready;
  assign w_f_hs      = bus.f_valid & w_f_ready;
  assign w_shift     = (r_state == STREAM) || (r_state == FLUSH);
  assign w_flush_end = (r_state == FLUSH) && (r_flush_cnt == FLUSH_LAST);

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_w_hs) w_state_next = LOAD;
      LOAD:    w_state_next = STREAM;
      STREAM:  if (w_f_hs && bus.f_last) w_state_next = FLUSH;
      FLUSH:   if (w_flush_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // w_ready is masked while reset is held so every output reads zero then.
  always_comb begin
    w_w_ready = 1'b0;
    w_f_ready = 1'b0;
    w_ctrl    = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      IDLE: begin
        w_w_ready = nrst_in;
        w_busy    = 1'b0;
      end
      LOAD:    w_ctrl    = 1'b1;
      STREAM:  w_f_ready = 1'b1;
      default: w_busy    = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      r_flush_cnt <= '0;
    end else if (r_state == FLUSH) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end else begin
      r_flush_cnt <= '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      r_weight <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_w_hs) begin
        r_weight <= bus.w_data;
      end
      r_done <= w_flush_end;
    end
  end

  generate
    for (genvar gi = 0; gi < row; gi++) begin : lane_g
      logic [width-1:0] r_stage [0:gi];

      // Head takes the accepted element or a zero bubble; chains clear outside streaming.
      always_ff @(posedge clk_in) begin
        if (!nrst_in || !w_shift) begin
          for (int i = 0; i <= gi; i++) begin
            r_stage[i] <= '0;
          end
        end else begin
          r_stage[0] <= (r_state == STREAM && w_f_hs) ? bus.f_data[gi] : '0;
          for (int i = 1; i <= gi; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign bus.feature_out[gi] = r_stage[gi];
    end
  endgenerate

  assign bus.w_ready    = w_w_ready;
  assign bus.f_ready    = w_f_ready;
  assign bus.ctrl_out   = w_ctrl;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.weight_out = r_weight;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized tile-level bench: the expected FSM phase comes from the tile
// timeline and feature lanes from a history of accepted vectors.
module tb_systolic_feeder;
  localparam int W  = 8;
  localparam int R  = 3;
  localparam int C  = 3;
  localparam int NF = R + C - 1;

  typedef enum int {PH_IDLE, PH_LOAD, PH_STREAM, PH_FLUSH} ph_t;

  logic clk_in  = 1'b0;
  logic nrst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  systolic_feeder_if #(.width(W), .row(R), .col(C)) bus ();

  systolic_feeder #(.width(W), .row(R), .col(C)) dut (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .bus     (bus)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_rst = -1;
  logic [R-1:0][W-1:0] hist [0:4095];
  logic [C-1:0][W-1:0] exp_w = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic noise();
    bus.w_valid = 1'($urandom);
    bus.w_data  = {C{8'($urandom)}};
    bus.f_valid = 1'($urandom);
    bus.f_data  = {R{8'($urandom)}};
    bus.f_last  = 1'($urandom);
  endtask

  // Checks the outputs of the current cycle given the phase the tile is in, then advances.
  task automatic cycle(input ph_t ph, input bit done_exp);
    int idx;
    logic [W-1:0] lane_exp;
    #1;
    chk("w_ready", 64'(bus.w_ready), 64'((ph == PH_IDLE) && nrst_in));
    chk("f_ready", 64'(bus.f_ready), 64'(ph == PH_STREAM));
    chk("ctrl_out", 64'(bus.ctrl_out), 64'(ph == PH_LOAD));
    chk("busy", 64'(bus.busy), 64'(ph != PH_IDLE));
    chk("done", 64'(bus.done), 64'(done_exp));
    chk("weight_out", 64'(bus.weight_out), 64'(exp_w));
    for (int r = 0; r < R; r++) begin
      idx = cyc - 1 - r;
      lane_exp = (idx < 0 || idx <= last_rst) ? '0 : hist[idx][r];
      chk($sformatf("feature_out%0d", r), 64'(bus.feature_out[r]), 64'(lane_exp));
    end
    hist[cyc] = (ph == PH_STREAM && bus.f_valid) ? bus.f_data : '0;
    if (!nrst_in) begin
      exp_w    = '0;
      last_rst = cyc;
    end else if (ph == PH_IDLE && bus.w_valid) begin
      exp_w = bus.w_data;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic run_tile(input int nvec, input bit directed, input int rst_at_flush);
    int sent;
    repeat ($urandom_range(0, 2)) begin
      noise();
      bus.w_valid = 1'b0;
      cycle(PH_IDLE, 1'b0);
    end
    noise();
    bus.w_valid = 1'b1;
    if (directed) bus.w_data = {8'd3, 8'd2, 8'd1};
    cycle(PH_IDLE, 1'b0);
    noise();
    cycle(PH_LOAD, 1'b0);
    sent = 0;
    while (sent < nvec) begin
      noise();
      bus.f_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (bus.f_valid) begin
        if (directed) bus.f_data = (sent == 0) ? {8'd12, 8'd11, 8'd10} : {8'd22, 8'd21, 8'd20};
        bus.f_last = (sent == nvec - 1);
        sent++;
      end
      cycle(PH_STREAM, 1'b0);
    end
    for (int k = 0; k < NF; k++) begin
      noise();
      if (k == rst_at_flush) begin
        nrst_in = 1'b0;
        cycle(PH_FLUSH, 1'b0);
        noise();
        cycle(PH_IDLE, 1'b0);
        nrst_in = 1'b1;
        return;
      end
      cycle(PH_FLUSH, 1'b0);
    end
    noise();
    bus.w_valid = 1'b0;
    cycle(PH_IDLE, 1'b1);
  endtask

  initial begin
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.f_valid = 1'b0;
    bus.f_data  = '0;
    bus.f_last  = 1'b0;
    @(negedge clk_in);
    last_rst = 0;
    cyc      = 1;
    cycle(PH_IDLE, 1'b0);
    nrst_in = 1'b1;
    run_tile(2, 1'b1, -1);
    for (int t = 0; t < 20; t++) begin
      run_tile($urandom_range(1, 6), 1'b0, -1);
    end
    run_tile(3, 1'b0, 2);
    run_tile(1, 1'b0, -1);
    run_tile(2, 1'b0, 0);
    run_tile(4, 1'b0, NF - 1);
    run_tile(1, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
